uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/awg_pkg.sv | 16 +
 rtl/bit_sync.sv | 27 ++
 rtl/uart_rx.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/awg_pkg.sv
// Shared types and constants for the serial command receive path.
package awg_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // ASCII digit bounds, for the downstream command decoder
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

endpackage : awg_pkg

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; both stages come out of reset at RESET_VAL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : bit_sync

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at mid-bit, LSB-first data,
// stop-bit check, with one-cycle rd / frame_err strobes.
// CLK_HZ / BAUD must come to at least 4 clocks per bit.
module uart_rx
  import awg_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] cmd,
  output logic       rd,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Terminal counts: one full bit period and half a bit period
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;

  rx_state_e        state_q,     state_d;
  logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       cmd_q,       cmd_d;
  logic             rd_q,        rd_d;
  logic             frame_err_q, frame_err_d;
  // armed_q drops after a bad stop bit so a held-low line (break) cannot
  // retrigger; it re-arms once the line is seen high again in IDLE.
  logic             armed_q,     armed_d;

  bit_sync #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  // Next-state logic for the receive FSM, counters, data and strobes
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    cmd_d       = cmd_q;
    armed_d     = armed_q;
    rd_d        = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          // Line back high by mid start bit means it was a glitch
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_s;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (clk_cnt_q == FULL_LAST) begin
          // Leaving at mid stop bit keeps back-to-back frames aligned
          clk_cnt_d = '0;
          state_d   = ST_IDLE;
          if (rx_s) begin
            cmd_d = shift_q;
            rd_d  = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register all FSM state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      cmd_q       <= 8'h00;
      rd_q        <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      cmd_q       <= cmd_d;
      rd_q        <= rd_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  assign cmd       = cmd_q;
  assign rd        = rd_q;
  assign frame_err = frame_err_q;

endmodule : uart_rx
